// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decryptor, one round per clock
// Inverse key schedule runs on the fly from the round-10 key back to the cipher key.
module aes_inv_cipher_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipher_text,
   input  logic [127:0] last_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic [127:0] key0
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       state, state_nxt;
   logic [127:0] st, rk, prev, ark, mixed;
   logic [3:0]   rnd;
   logic [31:0]  w0, w1, w2, w3, p0, p1, p2, p3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the field inverse (and maps 0 to 0), built from successive squares
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign in_ready = (state == IDLE) && !rst;

   assign {w0, w1, w2, w3} = rk;
   assign p3    = w3 ^ w2;
   assign p2    = w2 ^ w1;
   assign p1    = w1 ^ w0;
   assign p0    = w0 ^ {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])}
                     ^ {rcon(rnd), 24'h0};
   assign prev  = {p0, p1, p2, p3};
   assign ark   = inv_shift_sub(st) ^ prev;
   assign mixed = inv_mix(ark);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)     state_nxt = ROUND;
         ROUND:   if (rnd == 4'd1)  state_nxt = DONE;
         DONE:    if (out_ready)    state_nxt = IDLE;
         default:                   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         st        <= '0;
         rk        <= '0;
         rnd       <= 4'd0;
         plaintext <= '0;
         key0      <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               st  <= cipher_text ^ last_key;
               rk  <= last_key;
               rnd <= 4'd10;
            end
            ROUND: begin
               rk  <= prev;
               rnd <= rnd - 4'd1;
               // the final round skips InvMixColumns
               if (rnd == 4'd1) begin
                  st        <= ark;
                  plaintext <= ark;
                  key0      <= prev;
                  out_valid <= 1'b1;
               end else begin
                  st <= mixed;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption engine; the inverse of the unrolled combinational `aes` encryptor.
- Takes a 128-bit ciphertext and the round-10 (last) round key, which is exactly the encryptor's `keyout`.
- Recovers the plaintext and the original cipher key using an on-the-fly inverse key schedule, one round per clock.
- Sits beside the encryptor as the receive/decrypt path, with valid/ready handshakes on both sides.

Parameters:
none (AES-128 only; Nr = 10 fixed)

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext/key presented.
- in_ready  output  1  block can accept a new job.
- cipher_text  input  128  ciphertext, FIPS-197 byte order (byte 0 = bits [127:120]).
- last_key  input  128  round-10 round key.
- out_valid  output  1  plaintext/key0 valid.
- out_ready  input  1  consumer accepts the result.
- plaintext  output  128  decrypted block.
- key0  output  128  recovered cipher key (round-0 key).

Behaviour:
- Reset: synchronous, active-high; sampled on the rising edge of clk.
  - FSM goes to IDLE.
  - plaintext = 0, key0 = 0, out_valid = 0.
  - Round counter = 0; internal state and key registers = 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after reset deasserts.
- FSM states: IDLE, ROUND, DONE.
- in_ready = (FSM == IDLE) && !rst. It is combinational from state only and has no dependency on in_valid.
- IDLE:
  - Acceptance occurs when in_valid && in_ready at an edge (edge A0).
  - On A0: st <= cipher_text ^ last_key; rk <= last_key; rnd <= 10; FSM -> ROUND.
  - in_valid without in_ready is ignored; inputs need not be held after A0.
- ROUND: one iteration per edge, for rnd = 10 down to 1.
  - Inverse key step, with prev = inv_ks(rk, Rcon[rnd]) and rk = w0..w3 (w0 = bits [127:96]):
    - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0.
    - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[rnd], 24'h0}.
    - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Data step, rnd > 1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ prev).
  - Data step, rnd == 1: st <= InvSubBytes(InvShiftRows(st)) ^ prev, with no InvMixColumns.
  - rk <= prev; rnd <= rnd - 1.
  - When rnd == 1: plaintext and key0 are loaded with the final st/prev, out_valid <= 1, FSM -> DONE.
  - Result: out_valid is first high after edge A0+10. Latency is 10 cycles from acceptance.
  - The inverse S-box is a combinational 16-byte lookup. Only one round's datapath is instantiated, no unrolling.
- DONE:
  - plaintext, key0 and out_valid are held stable until out_valid && out_ready at an edge.
  - That edge sets out_valid <= 0 and FSM -> IDLE; in_ready is 1 in the next cycle.
  - plaintext and key0 keep their last value after the handshake; they are only meaningful while out_valid = 1.
  - out_ready is don't-care outside DONE.
- Throughput: at most one block per 12 cycles with out_ready tied high (accept, 10 rounds, handshake, IDLE). No overlap of jobs.
- Reset mid-operation (ROUND or DONE): the job is abandoned, all outputs take their reset values, and no out_valid pulse follows.
- Simultaneous rst and in_valid: reset wins and nothing is accepted.
- Simultaneous rst and out_ready in DONE: reset wins and the result is discarded.
- Inputs are not sampled outside the acceptance edge. Changing cipher_text/last_key during ROUND must not affect the result.

Test Plan:
- FIPS-197 C.1: cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, last_key=13111d7fe3944a17f307a78b4d2b30c5, out_ready=1 -> out_valid first high exactly 10 cycles after acceptance; plaintext=00112233445566778899aabbccddeeff; key0=000102030405060708090a0b0c0d0e0f.
- FIPS-197 App. B: cipher_text=3925841d02dc09fbdc118597196a0b32, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 -> plaintext=3243f6a8885a308d313198a2e0370734; key0=2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid, plaintext and key0 stable; in_ready=0 throughout; a new in_valid is ignored. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-round: assert rst at round 5 of the C.1 job -> outputs zero, out_valid never rises; a new App. B job then completes correctly.
- Input perturbation and loopback:
  - Randomize cipher_text/last_key every cycle during ROUND -> result still matches the vector captured at acceptance.
  - Loop 200 random plaintext/key pairs through `aes`, then this block -> plaintext and key0 match the originals.
